// File: rtl/modn_updown_counter_pkg.sv
// rtl/modn_updown_counter_pkg.sv - shared constants and parameter checks for the mod-N counter
package modn_updown_counter_pkg;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    // True when a WIDTH-bit count can hold every state 0..modulus-1.
    function automatic bit width_fits(input int modulus, input int width);
        return ($clog2(modulus) <= width);
    endfunction

    // Full legality check used at elaboration.
    function automatic bit params_ok(input int modulus, input int width, input int reset_val);
        return (width >= 1) && (modulus >= 2) && width_fits(modulus, width)
            && (reset_val >= 0) && (reset_val < modulus);
    endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// rtl/modn_updown_counter_if.sv - control and status bundle of one counter digit
interface modn_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             wrap;
    logic             load_err;
    logic             tc;

    modport master (
        output en, load, mode, data_in,
        input  data_out, wrap, load_err, tc
    );

    modport slave (
        input  en, load, mode, data_in,
        output data_out, wrap, load_err, tc
    );
endinterface

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - parametrised modulo-N up/down counter with load check and cascade tc
module modn_updown_counter
    import modn_updown_counter_pkg::*;
#(
    parameter int MODULUS   = 12,
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    modn_updown_counter_if.slave  bus
);

    if (!params_ok(MODULUS, WIDTH, RESET_VAL)) begin : g_bad_params
        $fatal(1, "modn_updown_counter: illegal MODULUS/WIDTH/RESET_VAL combination");
    end

    // Comparisons run one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   data_in_ext;

    assign count_ext   = {1'b0, count_q};
    assign data_in_ext = {1'b0, bus.data_in};

    // Next state: load (range-checked) beats counting, counting beats hold.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (data_in_ext < MOD_EXT) begin
                count_d = bus.data_in;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.mode == MODE_DOWN) begin
                // Out-of-range states are folded into the wrap path defensively.
                if ((count_ext == '0) || (count_ext >= MOD_EXT)) begin
                    count_d = TOP_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                if (count_ext >= TOP_EXT) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    // State and registered pulses; reset clears the pulses so an aborted count never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= RST_VAL;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.data_out = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    // Zero-latency carry so the next digit advances on the same edge this one wraps.
    assign bus.tc = bus.en & ((bus.mode == MODE_UP) ? (count_ext == TOP_EXT)
                                                    : (count_ext == '0));

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - self-checking bench for modn_updown_counter
module tb_modn_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    modn_updown_counter_if #(.WIDTH(4)) if12 ();
    modn_updown_counter_if #(.WIDTH(4)) ifrv ();
    modn_updown_counter_if #(.WIDTH(4)) if16 ();
    modn_updown_counter_if #(.WIDTH(4)) iflo ();
    modn_updown_counter_if #(.WIDTH(4)) ifhi ();

    modn_updown_counter #(.MODULUS(12), .WIDTH(4), .RESET_VAL(0)) u_m12 (.clk(clk), .rst(rst), .bus(if12));
    modn_updown_counter #(.MODULUS(12), .WIDTH(4), .RESET_VAL(5)) u_rv5 (.clk(clk), .rst(rst), .bus(ifrv));
    modn_updown_counter #(.MODULUS(16), .WIDTH(4), .RESET_VAL(0)) u_m16 (.clk(clk), .rst(rst), .bus(if16));
    modn_updown_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) u_lo  (.clk(clk), .rst(rst), .bus(iflo));
    modn_updown_counter #(.MODULUS(6),  .WIDTH(4), .RESET_VAL(0)) u_hi  (.clk(clk), .rst(rst), .bus(ifhi));

    assign ifhi.en = iflo.tc;

    typedef struct {
        int load;
        int en;
        int mode;
        int din;
        int exp_out;
        int exp_wrap;
        int exp_err;
        int exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    int m_cnt;
    int m_wrap;
    int m_err;
    int r_load, r_en, r_mode, r_din, r_tc;

    initial begin
        if12.en = 0; if12.load = 0; if12.mode = 1; if12.data_in = 0;
        ifrv.en = 0; ifrv.load = 0; ifrv.mode = 1; ifrv.data_in = 0;
        if16.en = 0; if16.load = 0; if16.mode = 1; if16.data_in = 0;
        iflo.en = 0; iflo.load = 0; iflo.mode = 1; iflo.data_in = 0;
        ifhi.load = 0; ifhi.mode = 1; ifhi.data_in = 0;

        // Reset values.
        #12;
        chk("reset_out",      int'(if12.data_out), 0);
        chk("reset_wrap",     int'(if12.wrap), 0);
        chk("reset_err",      int'(if12.load_err), 0);
        chk("reset_rv5_out",  int'(ifrv.data_out), 5);
        @(negedge clk);
        rst = 1'b1;
        edge_settle();
        chk("post_reset_hold", int'(if12.data_out), 0);

        // Directed table on the mod-12 instance.
        vecs.push_back('{1, 1, 1, 10, 10, 0, 0, 0});
        vecs.push_back('{0, 1, 1,  0, 11, 0, 0, 1});
        vecs.push_back('{0, 1, 1,  0,  0, 1, 0, 0});
        vecs.push_back('{0, 1, 1,  0,  1, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  1,  1, 0, 0, 0});
        vecs.push_back('{0, 1, 0,  0,  0, 0, 0, 1});
        vecs.push_back('{0, 1, 0,  0, 11, 1, 0, 0});
        vecs.push_back('{0, 1, 0,  0, 10, 0, 0, 0});
        vecs.push_back('{1, 1, 1,  4,  4, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 13,  4, 0, 1, 0});
        vecs.push_back('{0, 0, 1,  0,  4, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 11, 11, 0, 0, 1});
        vecs.push_back('{1, 1, 1, 12, 11, 0, 1, 1});
        vecs.push_back('{1, 0, 1,  6,  6, 0, 0, 0});
        for (int k = 0; k < 5; k++) vecs.push_back('{0, 0, k % 2, 0, 6, 0, 0, 0});
        vecs.push_back('{1, 0, 0,  0,  0, 0, 0, 0});
        vecs.push_back('{0, 0, 0,  0,  0, 0, 0, 0});

        ifrv.load = 1; ifrv.data_in = 2;
        foreach (vecs[i]) begin
            if12.load    = vecs[i].load[0];
            if12.en      = vecs[i].en[0];
            if12.mode    = vecs[i].mode[0];
            if12.data_in = vecs[i].din[3:0];
            edge_settle();
            ifrv.load = 0;
            chk($sformatf("vec%0d_out", i),  int'(if12.data_out), vecs[i].exp_out);
            chk($sformatf("vec%0d_wrap", i), int'(if12.wrap), vecs[i].exp_wrap);
            chk($sformatf("vec%0d_err", i),  int'(if12.load_err), vecs[i].exp_err);
            chk($sformatf("vec%0d_tc", i),   int'(if12.tc), vecs[i].exp_tc);
        end
        chk("rv5_loaded", int'(ifrv.data_out), 2);

        // Asynchronous reset mid-count with load_err high.
        if12.load = 1; if12.en = 0; if12.data_in = 7;
        edge_settle();
        if12.data_in = 15;
        edge_settle();
        chk("pre_rst_out", int'(if12.data_out), 7);
        chk("pre_rst_err", int'(if12.load_err), 1);
        if12.load = 0; if12.en = 1; if12.mode = 1;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out",  int'(if12.data_out), 0);
        chk("async_rst_wrap", int'(if12.wrap), 0);
        chk("async_rst_err",  int'(if12.load_err), 0);
        chk("async_rst_rv5",  int'(ifrv.data_out), 5);
        edge_settle();
        chk("rst_held_out", int'(if12.data_out), 0);
        rst = 1'b1;
        edge_settle();
        chk("rst_release_out",  int'(if12.data_out), 1);
        chk("rst_release_wrap", int'(if12.wrap), 0);
        if12.en = 0;

        // Full-range modulus: 15 -> 0 up and 0 -> 15 down.
        if16.load = 1; if16.data_in = 15;
        edge_settle();
        if16.load = 0; if16.en = 1; if16.mode = 1;
        #1;
        chk("m16_tc_up", int'(if16.tc), 1);
        edge_settle();
        chk("m16_up_out",  int'(if16.data_out), 0);
        chk("m16_up_wrap", int'(if16.wrap), 1);
        if16.mode = 0;
        edge_settle();
        chk("m16_dn_out",  int'(if16.data_out), 15);
        chk("m16_dn_wrap", int'(if16.wrap), 1);
        if16.en = 0;

        // Cascade mod-10 into mod-6: 59 rolls to 00.
        iflo.load = 1; iflo.data_in = 9; ifhi.load = 1; ifhi.data_in = 5;
        edge_settle();
        iflo.load = 0; ifhi.load = 0; iflo.en = 1;
        #1;
        chk("casc_lo_tc", int'(iflo.tc), 1);
        chk("casc_hi_tc", int'(ifhi.tc), 1);
        edge_settle();
        chk("casc_lo_out",  int'(iflo.data_out), 0);
        chk("casc_hi_out",  int'(ifhi.data_out), 0);
        chk("casc_lo_wrap", int'(iflo.wrap), 1);
        chk("casc_hi_wrap", int'(ifhi.wrap), 1);
        edge_settle();
        chk("casc_lo_next", int'(iflo.data_out), 1);
        chk("casc_hi_hold", int'(ifhi.data_out), 0);
        chk("casc_hi_wrap0", int'(ifhi.wrap), 0);
        iflo.en = 0;

        // Randomised run against a modular-arithmetic reference.
        m_cnt = int'(if12.data_out);
        for (int i = 0; i < 400; i++) begin
            r_load = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r_en   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r_mode = int'($urandom_range(0, 1));
            r_din  = int'($urandom_range(0, 15));
            if12.load = r_load[0]; if12.en = r_en[0]; if12.mode = r_mode[0]; if12.data_in = r_din[3:0];
            #1;
            r_tc = (r_en == 1 && ((r_mode == 1 && m_cnt == 11) || (r_mode == 0 && m_cnt == 0))) ? 1 : 0;
            chk("rand_tc", int'(if12.tc), r_tc);
            m_wrap = 0;
            m_err  = 0;
            if (r_load == 1) begin
                if (r_din < 12) m_cnt = r_din;
                else m_err = 1;
            end else if (r_en == 1) begin
                if (r_mode == 1) begin
                    m_wrap = (m_cnt == 11) ? 1 : 0;
                    m_cnt  = (m_cnt + 1) % 12;
                end else begin
                    m_wrap = (m_cnt == 0) ? 1 : 0;
                    m_cnt  = (m_cnt + 11) % 12;
                end
            end
            edge_settle();
            chk("rand_out",  int'(if12.data_out), m_cnt);
            chk("rand_wrap", int'(if12.wrap), m_wrap);
            chk("rand_err",  int'(if12.load_err), m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
